// File: rtl/adc_capture_ctrl_if.sv
// Stream interface between the capture controller and the DMA input.
// The master drives data, valid and last. The slave returns ready.
interface adc_capture_ctrl_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/adc_capture_ctrl.sv
// Frame capture sequencer: arm, optional trigger, accept frame_len packed words,
// then stream them out through a small FIFO with tlast on the final word.
module adc_capture_ctrl #(
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [LEN_W-1:0]     frame_len,
  input  logic                 trig_en,
  input  logic                 trig_in,
  input  logic [31:0]          in_data,
  input  logic                 in_valid,
  adc_capture_ctrl_if.master   m_axis,
  output logic                 busy,
  output logic                 done,
  output logic                 overflow,
  output logic [LEN_W-1:0]     word_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [LEN_W-1:0] r_frame_len;
  logic [LEN_W-1:0] r_word_cnt;
  logic             r_overflow;
  logic             r_busy;
  logic             r_done;
  logic             r_trig_prev;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic [31:0]      r_mem_data [FIFO_DEPTH];
  logic             r_mem_last [FIFO_DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_abort;
  logic w_word;
  logic w_last;
  logic w_push;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_pop   = !w_empty && m_axis.tready;
  assign w_abort = abort && (r_state != S_IDLE);
  assign w_word  = (r_state == S_CAPTURE) && in_valid && !w_abort;
  assign w_last  = (r_word_cnt == (r_frame_len - LEN_W'(1)));
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign w_push  = w_word && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr[PTR_W-1:0]] <= in_data;
      r_mem_last[r_wr_ptr[PTR_W-1:0]] <= w_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_frame_len <= '0;
      r_word_cnt  <= '0;
      r_overflow  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_trig_prev <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
    end else begin
      r_trig_prev <= trig_in;
      if (w_abort) begin
        r_state  <= S_IDLE;
        r_busy   <= 1'b0;
        r_done   <= 1'b0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
        end
        case (r_state)
          S_IDLE: begin
            if (start && !abort && (frame_len != '0)) begin
              r_frame_len <= frame_len;
              r_word_cnt  <= '0;
              r_overflow  <= 1'b0;
              r_busy      <= 1'b1;
              r_state     <= trig_en ? S_ARMED : S_CAPTURE;
            end
          end
          S_ARMED: begin
            if (trig_in && !r_trig_prev) begin
              r_state <= S_CAPTURE;
            end
          end
          S_CAPTURE: begin
            if (in_valid) begin
              r_word_cnt <= r_word_cnt + LEN_W'(1);
              if (w_full && !w_pop) begin
                r_overflow <= 1'b1;
              end
              if (w_last) begin
                r_state <= S_DRAIN;
              end
            end
          end
          S_DRAIN: begin
            if (w_empty) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign m_axis.tdata  = r_mem_data[r_rd_ptr[PTR_W-1:0]];
  assign m_axis.tvalid = !w_empty;
  assign m_axis.tlast  = !w_empty && r_mem_last[r_rd_ptr[PTR_W-1:0]];

  assign busy     = r_busy;
  assign done     = r_done;
  assign overflow = r_overflow;
  assign word_cnt = r_word_cnt;

endmodule
